engine_scoreboard: RTL and testbench

//  Tracks in-flight operations per compute/DMA engine for the microcode engine.

---
 rtl/npu_pkg.sv | 22 ++
 rtl/scoreboard_counter.sv | 37 +++
 rtl/engine_scoreboard.sv | 111 +++++++++++
 tb/tb_engine_scoreboard.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared NPU definitions: engine count, engine id type and engine index constants
// used by decode and the engine scoreboard.
package npu_pkg;

  localparam int unsigned NUM_ENGINES = 6;
  localparam int unsigned ENG_ID_W    = $clog2(NUM_ENGINES);

  typedef logic [ENG_ID_W-1:0] engine_id_t;

  localparam engine_id_t ENG_GEMM   = engine_id_t'(0);
  localparam engine_id_t ENG_VEC    = engine_id_t'(1);
  localparam engine_id_t ENG_ACT    = engine_id_t'(2);
  localparam engine_id_t ENG_POOL   = engine_id_t'(3);
  localparam engine_id_t ENG_DMA_LD = engine_id_t'(4);
  localparam engine_id_t ENG_DMA_ST = engine_id_t'(5);

  // Bits needed to hold 0..max inclusive.
  function automatic int unsigned cnt_width(input int unsigned max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/scoreboard_counter.sv
// One per-engine outstanding-operation counter: saturating up/down, never wraps,
// flags a completion that arrives with nothing outstanding.
module scoreboard_counter #(
  parameter int unsigned MAX_OUTST = 3,
  parameter int unsigned CNT_W     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             done,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_next,
  output logic             underflow
);

  logic [CNT_W-1:0] cnt_q;

  // A done coinciding with an issue cancels it, even at zero.
  always_comb begin
    cnt_next  = cnt_q;
    underflow = 1'b0;
    if (inc && !done) begin
      if (cnt_q != CNT_W'(MAX_OUTST)) cnt_next = cnt_q + CNT_W'(1);
    end else if (!inc && done) begin
      if (cnt_q != '0) cnt_next = cnt_q - CNT_W'(1);
      else             underflow = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_next;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/engine_scoreboard.sv
// Per-engine in-flight operation tracker producing busy/all_idle and sticky errors.
// Optional watchdog enabled by defining SCOREBOARD_TIMEOUT_EN.
module engine_scoreboard
  import npu_pkg::*;
#(
  parameter int unsigned NUM_ENGINES = npu_pkg::NUM_ENGINES,
  parameter int unsigned MAX_OUTST   = 3,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           issue_valid,
  input  logic [$clog2(NUM_ENGINES)-1:0] issue_eng,
  output logic                           issue_ready,
  input  logic [NUM_ENGINES-1:0]         eng_done,
  output logic [NUM_ENGINES-1:0]         busy,
  output logic                           all_idle,
  input  logic                           err_clr,
  output logic                           err_underflow,
  output logic                           err_bad_eng,
  output logic                           timeout
);

  localparam int unsigned IdW  = $clog2(NUM_ENGINES);
  localparam int unsigned CntW = cnt_width(MAX_OUTST);

  logic [CntW-1:0]        cnt      [NUM_ENGINES];
  logic [CntW-1:0]        cnt_next [NUM_ENGINES];
  logic [NUM_ENGINES-1:0] inc_vec;
  logic [NUM_ENGINES-1:0] uf_vec;
  logic [NUM_ENGINES-1:0] busy_d;
  logic                   id_ok;
  logic                   sel_full;
  logic                   accept;
  logic                   bad_set;

  assign id_ok = int'(issue_eng) < int'(NUM_ENGINES);

  // Ready looks only at the registered count, so a same-cycle done cannot raise it.
  always_comb begin
    sel_full = 1'b1;
    for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
      if (issue_eng == IdW'(i)) sel_full = (cnt[i] == CntW'(MAX_OUTST));
    end
  end

  assign issue_ready = id_ok & ~sel_full;
  assign accept      = issue_valid & issue_ready;
  assign bad_set     = issue_valid & ~id_ok;

  for (genvar i = 0; i < NUM_ENGINES; i++) begin : g_eng
    assign inc_vec[i] = accept && (issue_eng == IdW'(i));

    scoreboard_counter #(
      .MAX_OUTST (MAX_OUTST),
      .CNT_W     (CntW)
    ) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (inc_vec[i]),
      .done      (eng_done[i]),
      .cnt       (cnt[i]),
      .cnt_next  (cnt_next[i]),
      .underflow (uf_vec[i])
    );

    assign busy_d[i] = (cnt_next[i] != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy          <= '0;
      all_idle      <= 1'b1;
      err_underflow <= 1'b0;
      err_bad_eng   <= 1'b0;
    end else begin
      busy          <= busy_d;
      all_idle      <= ~|busy_d;
      err_underflow <= (err_underflow & ~err_clr) | (|uf_vec);
      err_bad_eng   <= (err_bad_eng & ~err_clr) | bad_set;
    end
  end

`ifdef SCOREBOARD_TIMEOUT_EN
  localparam int unsigned WdW = cnt_width(TIMEOUT_CYC);

  logic [WdW-1:0] wd_q, wd_d;
  logic           timeout_q;

  always_comb begin
    wd_d = wd_q;
    if (all_idle || (|eng_done))           wd_d = '0;
    else if (wd_q != WdW'(TIMEOUT_CYC))    wd_d = wd_q + WdW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= (timeout_q & ~err_clr) | (wd_d == WdW'(TIMEOUT_CYC));
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_engine_scoreboard.sv
// Self-checking bench for engine_scoreboard: vector table plus reset and watchdog sequences.
module tb_engine_scoreboard;
  import npu_pkg::*;

  localparam int unsigned NE = 6;
  localparam int unsigned MO = 3;
  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       issue_valid;
  logic [2:0] issue_eng;
  logic       issue_ready;
  logic [5:0] eng_done;
  logic [5:0] busy;
  logic       all_idle;
  logic       err_clr;
  logic       err_underflow;
  logic       err_bad_eng;
  logic       timeout;

  engine_scoreboard #(
    .NUM_ENGINES (NE),
    .MAX_OUTST   (MO),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_eng     (issue_eng),
    .issue_ready   (issue_ready),
    .eng_done      (eng_done),
    .busy          (busy),
    .all_idle      (all_idle),
    .err_clr       (err_clr),
    .err_underflow (err_underflow),
    .err_bad_eng   (err_bad_eng),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] eng;
    logic [5:0] done;
    logic       clr;
    logic       rdy;
  } vec_t;

  typedef struct {
    logic [5:0] busy;
    logic       idle;
    logic       uf;
    logic       bad;
  } exp_t;

  exp_t q[$];
  int   m_cnt[NE];
  logic m_uf;
  logic m_bad;
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t tbl[25];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NE; i++) m_cnt[i] = 0;
    m_uf  = 1'b0;
    m_bad = 1'b0;
    q.delete();
  endtask

  // Drive one cycle, predict the registered outputs, then compare after the edge.
  task automatic step(input logic v, input logic [2:0] eng, input logic [5:0] done,
                      input logic clr, input logic exp_rdy, input string nm);
    exp_t e;
    exp_t got;
    logic acc;
    logic rdy_m;
    issue_valid = v;
    issue_eng   = eng;
    eng_done    = done;
    err_clr     = clr;
    #2;
    chk({nm, " ready"}, 32'(issue_ready), 32'(exp_rdy));
    rdy_m = 1'b0;
    if (int'(eng) < NE) rdy_m = (m_cnt[eng] != MO);
    acc   = v & rdy_m;
    e.uf  = m_uf & ~clr;
    e.bad = (m_bad & ~clr) | (v && int'(eng) >= NE);
    for (int i = 0; i < NE; i++) begin
      logic inc;
      inc = acc && (int'(eng) == i);
      if (inc && !done[i]) m_cnt[i] = m_cnt[i] + 1;
      else if (!inc && done[i]) begin
        if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
        else              e.uf = 1'b1;
      end
      e.busy[i] = (m_cnt[i] != 0);
    end
    e.idle = (e.busy == 6'd0);
    m_uf   = e.uf;
    m_bad  = e.bad;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: scoreboard queue empty got 0 expected 1", nm);
    end else begin
      got = q.pop_front();
      chk({nm, " busy"},     32'(busy),          32'(got.busy));
      chk({nm, " all_idle"}, 32'(all_idle),      32'(got.idle));
      chk({nm, " err_uf"},   32'(err_underflow), 32'(got.uf));
      chk({nm, " err_bad"},  32'(err_bad_eng),   32'(got.bad));
    end
  endtask

  initial begin
    // v, eng, done, clr, expected ready
    tbl[0]  = '{1'b1, 3'd2, 6'h00, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 3'd2, 6'h00, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 3'd0, 6'h00, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 3'd0, 6'h00, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 3'd0, 6'h00, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 3'd0, 6'h04, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 3'd0, 6'h00, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 3'd0, 6'h00, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 3'd0, 6'h00, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 3'd0, 6'h00, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 3'd0, 6'h01, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 3'd0, 6'h00, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 3'd0, 6'h01, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 3'd0, 6'h01, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 3'd0, 6'h01, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 3'd1, 6'h00, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 3'd1, 6'h02, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 3'd1, 6'h02, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 3'd4, 6'h10, 1'b0, 1'b1};
    tbl[19] = '{1'b0, 3'd0, 6'h00, 1'b0, 1'b1};
    tbl[20] = '{1'b0, 3'd0, 6'h00, 1'b1, 1'b1};
    tbl[21] = '{1'b1, 3'd7, 6'h00, 1'b0, 1'b0};
    tbl[22] = '{1'b1, 3'd6, 6'h00, 1'b1, 1'b0};
    tbl[23] = '{1'b0, 3'd0, 6'h00, 1'b1, 1'b1};
    tbl[24] = '{1'b1, 3'd4, 6'h10, 1'b0, 1'b1};

    rst_n       = 1'b0;
    issue_valid = 1'b0;
    issue_eng   = 3'd0;
    eng_done    = 6'h00;
    err_clr     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset busy",     32'(busy),          32'h0);
    chk("reset all_idle", 32'(all_idle),      32'h1);
    chk("reset err_uf",   32'(err_underflow), 32'h0);
    chk("reset err_bad",  32'(err_bad_eng),   32'h0);
    chk("reset timeout",  32'(timeout),       32'h0);

    for (int i = 0; i < 25; i++) begin
      step(tbl[i].v, tbl[i].eng, tbl[i].done, tbl[i].clr, tbl[i].rdy,
           $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of a cycle with work outstanding.
    step(1'b1, 3'd5, 6'h00, 1'b0, 1'b1, "pre_rst_issue");
    step(1'b0, 3'd2, 6'h04, 1'b0, 1'b1, "pre_rst_uf");
    issue_valid = 1'b0;
    eng_done    = 6'h00;
    rst_n       = 1'b0;
    #1;
    chk("async_rst busy",     32'(busy),          32'h0);
    chk("async_rst all_idle", 32'(all_idle),      32'h1);
    chk("async_rst err_uf",   32'(err_underflow), 32'h0);
    chk("async_rst err_bad",  32'(err_bad_eng),   32'h0);
    chk("async_rst ready",    32'(issue_ready),   32'h1);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Engine 3 never completes: watchdog fires after TO busy cycles when enabled.
    step(1'b1, 3'd3, 6'h00, 1'b0, 1'b1, "to_issue");
    for (int i = 0; i < 8; i++) step(1'b0, 3'd0, 6'h00, 1'b0, 1'b1, "to_wait_a");
    chk("timeout early", 32'(timeout), 32'h0);
    for (int i = 0; i < 12; i++) step(1'b0, 3'd0, 6'h00, 1'b0, 1'b1, "to_wait_b");
`ifdef SCOREBOARD_TIMEOUT_EN
    chk("timeout fired", 32'(timeout), 32'h1);
`else
    chk("timeout off", 32'(timeout), 32'h0);
`endif
    step(1'b0, 3'd0, 6'h08, 1'b0, 1'b1, "to_done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
